wb_arbiter_scoreboard: RTL and testbench

Shares the single register-file write port between NREQ writeback sources (ALU, LSU, MUL/DIV) using round-robin arbitration. Drives the regfile write port (o_rd_wren/o_rd_addr/o_rd_data) from registered outputs. Keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards against writes still in flight. Sits between the execute-stage units and the register file; the decode stage connects to the issue interface.

---
 rtl/wb_arbiter_scoreboard.sv | 123 ++++++++++++
 tb/tb_wb_arbiter_scoreboard.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_scoreboard.sv
// wb_arbiter_scoreboard
//   Round-robin arbiter that shares the single register-file write port
//   between NREQ writeback sources (0 = ALU, 1 = LSU, 2 = MDU, ...). It also
//   keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards
//   against writes still in flight.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_wb_valid[NREQ]      requester i holds a result
//   i_wb_rd[5*NREQ]       destination register of requester i (bits 5i+4:5i)
//   i_wb_data[XLEN*NREQ]  result data of requester i
//   o_wb_ready[NREQ]      one-hot grant (combinational)
//   i_issue_*             instruction presented by decode
//   o_issue_stall         hazard against the busy scoreboard (combinational)
//   o_rd_wren/addr/data   registered register-file write port
//   o_busy[32]            scoreboard vector
module wb_arbiter_scoreboard #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_wb_valid,
    input  logic [5*NREQ-1:0]    i_wb_rd,
    input  logic [XLEN*NREQ-1:0] i_wb_data,
    output logic [NREQ-1:0]      o_wb_ready,
    input  logic                 i_issue_valid,
    input  logic [4:0]           i_issue_rs1,
    input  logic [4:0]           i_issue_rs2,
    input  logic [4:0]           i_issue_rd,
    input  logic                 i_issue_rd_en,
    output logic                 o_issue_stall,
    output logic                 o_rd_wren,
    output logic [4:0]           o_rd_addr,
    output logic [XLEN-1:0]      o_rd_data,
    output logic [31:0]          o_busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [4:0]      wb_rd   [NREQ];
    logic [XLEN-1:0] wb_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign wb_rd[g]   = i_wb_rd[5*g +: 5];
        assign wb_data[g] = i_wb_data[XLEN*g +: XLEN];
    end

    logic [PW-1:0]   ptr;
    logic [31:0]     busy;
    logic [31:0]     busy_next;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;
    logic            issue_fire;

    // Search starts one past the last winner, so the last winner has the
    // lowest priority in the next cycle.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        o_wb_ready  = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!grant_found && i_wb_valid[PW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
        if (grant_found) begin
            o_wb_ready[grant_idx] = 1'b1;
        end
        grant_rd   = wb_rd[grant_idx];
        grant_data = wb_data[grant_idx];
    end

    assign o_issue_stall = i_issue_valid &&
                           (busy[i_issue_rs1] || busy[i_issue_rs2] ||
                            (i_issue_rd_en && busy[i_issue_rd]));

    assign issue_fire = i_issue_valid && !o_issue_stall && i_issue_rd_en &&
                        (i_issue_rd != 5'd0);

    // Clear is applied before set so a new reservation wins over a
    // completing write to the same register.
    always_comb begin
        busy_next = busy;
        if (o_rd_wren) begin
            busy_next[o_rd_addr] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[i_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr       <= PW'(NREQ - 1);
            busy      <= '0;
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else begin
            busy <= busy_next;
            if (grant_found) begin
                ptr       <= grant_idx;
                o_rd_addr <= grant_rd;
                o_rd_data <= grant_data;
                // Results targeting x0 are consumed but never written.
                o_rd_wren <= (grant_rd != 5'd0);
            end else begin
                o_rd_wren <= 1'b0;
            end
        end
    end

    assign o_busy = busy;

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// Testbench for wb_arbiter_scoreboard: directed scenarios plus a random phase,
// with a reference arbiter/scoreboard model and a queue of expected writes.
module tb_wb_arbiter_scoreboard;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      wb_valid;
    logic [5*NREQ-1:0]    wb_rd;
    logic [XLEN*NREQ-1:0] wb_data;
    logic [NREQ-1:0]      wb_ready;
    logic                 issue_valid;
    logic [4:0]           issue_rs1;
    logic [4:0]           issue_rs2;
    logic [4:0]           issue_rd;
    logic                 issue_rd_en;
    logic                 issue_stall;
    logic                 rd_wren;
    logic [4:0]           rd_addr;
    logic [XLEN-1:0]      rd_data;
    logic [31:0]          busy;

    wb_arbiter_scoreboard #(
        .XLEN (XLEN),
        .NREQ (NREQ)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .o_wb_ready    (wb_ready),
        .i_issue_valid (issue_valid),
        .i_issue_rs1   (issue_rs1),
        .i_issue_rs2   (issue_rs2),
        .i_issue_rd    (issue_rd),
        .i_issue_rd_en (issue_rd_en),
        .o_issue_stall (issue_stall),
        .o_rd_wren     (rd_wren),
        .o_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model, evaluated mid-cycle ----------------
    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t         q[$];
    int          mptr;
    logic [31:0] mbusy;
    bit          started = 0;
    int          waitc[NREQ];

    always @(negedge clk) begin
        logic [NREQ-1:0] mg;
        bit              mfound;
        bit              mstall;
        bit              popped;
        int              gi;
        int              j;
        logic [4:0]      clr;
        logic [4:0]      grd;
        wb_t             e;
        mg     = '0;
        mfound = 0;
        gi     = 0;
        popped = 0;
        clr    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (mptr + k) % NREQ;
            if (!mfound && wb_valid[j]) begin
                mfound = 1;
                gi     = j;
            end
        end
        if (mfound) mg[gi] = 1'b1;
        mstall = issue_valid && (mbusy[issue_rs1] || mbusy[issue_rs2] ||
                                 (issue_rd_en && mbusy[issue_rd]));
        if (started) begin
            check("wren", rd_wren, q.size() != 0);
            if (q.size() != 0) begin
                e      = q.pop_front();
                popped = 1;
                clr    = e.addr;
                check("addr", rd_addr, e.addr);
                check("data", rd_data, e.data);
            end
            check("busy", busy, mbusy);
            check("ready", wb_ready, mg);
            check("stall", issue_stall, mstall);
        end
        if (reset) begin
            q.delete();
            mptr    = NREQ - 1;
            mbusy   = '0;
            started = 1;
            for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        end else if (started) begin
            if (mfound) begin
                mptr = gi;
                grd  = wb_rd[5*gi +: 5];
                if (grd != 5'd0) q.push_back({grd, wb_data[XLEN*gi +: XLEN]});
            end
            for (int i = 0; i < NREQ; i++) begin
                if (wb_valid[i]) begin
                    waitc[i]++;
                    if (mg[i]) begin
                        check("starve", waitc[i] <= NREQ, 1);
                        waitc[i] = 0;
                    end
                end else begin
                    waitc[i] = 0;
                end
            end
            if (popped) mbusy[clr] = 1'b0;
            if (issue_valid && !mstall && issue_rd_en && issue_rd != 5'd0)
                mbusy[issue_rd] = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic en);
        issue_valid = v;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_rd_en = en;
    endtask

    task automatic set_wb(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_rd[5*i +: 5]       = rd;
        wb_data[XLEN*i +: XLEN] = d;
    endtask

    logic [2:0]  exp_rdy [5];
    logic [4:0]  exp_addr[5];
    logic [NREQ-1:0] r;

    initial begin
        exp_rdy  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_addr = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd5};
        reset    = 1'b1;
        wb_valid = 3'b111;
        wb_rd    = '0;
        wb_data  = '0;
        set_wb(0, 5'd5, 32'h1000_0000);
        set_wb(1, 5'd6, 32'h1000_0001);
        set_wb(2, 5'd7, 32'h1000_0002);
        set_issue(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and round-robin order
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rr_ready", wb_ready, exp_rdy[c]);
            if (c == 0) begin
                check("rst_wren", rd_wren, 0);
                check("rst_busy", busy, 0);
            end else begin
                check("rr_wren", rd_wren, 1);
                check("rr_addr", rd_addr, exp_addr[c]);
            end
            tick();
        end
        wb_valid = '0;

        // RAW hazard on x9
        set_issue(1, 0, 0, 9, 1);
        @(negedge clk); check("raw_first", issue_stall, 0); tick();
        set_issue(1, 9, 0, 0, 0);
        @(negedge clk); check("raw_stall", issue_stall, 1); check("raw_busy", busy[9], 1); tick();
        wb_valid = 3'b010; set_wb(1, 5'd9, 32'hDEAD_BEEF);
        @(negedge clk); check("raw_ready", wb_ready, 3'b010); check("raw_stall2", issue_stall, 1); tick();
        wb_valid = '0;
        @(negedge clk);
        check("raw_wren", rd_wren, 1); check("raw_addr", rd_addr, 9);
        check("raw_data", rd_data, 32'hDEAD_BEEF); check("raw_stall3", issue_stall, 1); tick();
        @(negedge clk); check("raw_release", issue_stall, 0); check("raw_clr", busy[9], 0); tick();

        // WAW hazard and x0 handling
        set_issue(1, 0, 0, 4, 1);
        @(negedge clk); check("waw_first", issue_stall, 0); tick();
        @(negedge clk); check("waw_stall", issue_stall, 1); tick();
        set_issue(1, 0, 0, 0, 1);
        @(negedge clk); check("x0_issue", issue_stall, 0); tick();
        set_issue(0, 0, 0, 0, 0);
        wb_valid = 3'b001; set_wb(0, 5'd0, 32'h0000_00AA);
        @(negedge clk); check("x0_busy", busy, 32'h10); check("x0_ready", wb_ready, 3'b001); tick();
        set_wb(0, 5'd4, 32'h0000_0044);
        @(negedge clk); check("x0_wren", rd_wren, 0); tick();
        wb_valid = '0;
        @(negedge clk); check("w4_wren", rd_wren, 1); check("w4_addr", rd_addr, 4); tick();
        @(negedge clk); check("w4_clr", busy, 0); tick();

        // Reservation of x12 in the cycle right after its write clears it
        set_issue(1, 0, 0, 12, 1);
        tick();
        set_issue(0, 0, 0, 0, 0);
        wb_valid = 3'b100; set_wb(2, 5'd12, 32'h0000_000C);
        @(negedge clk); check("col_busy", busy[12], 1); check("col_ready", wb_ready, 3'b100); tick();
        wb_valid = '0;
        @(negedge clk); check("col_wren", rd_wren, 1); check("col_addr", rd_addr, 12); tick();
        set_issue(1, 0, 0, 12, 1);
        @(negedge clk); check("col_noStall", issue_stall, 0); check("col_clr", busy[12], 0); tick();
        set_issue(0, 0, 0, 0, 0);
        @(negedge clk); check("col_reset", busy[12], 1); tick();

        // Reset mid-operation with a pending grant
        wb_valid = 3'b100; set_wb(2, 5'd12, 32'h0000_0C0C);
        for (int i = 8; i < 12; i++) begin
            set_issue(1, 0, 0, 5'(i), 1);
            tick();
            wb_valid = '0;
        end
        set_issue(0, 0, 0, 0, 0);
        set_wb(0, 5'd1, 32'h1); set_wb(1, 5'd2, 32'h2); set_wb(2, 5'd3, 32'h3);
        wb_valid = 3'b111;
        reset    = 1'b1;
        @(negedge clk); check("mid_busy", busy, 32'h0000_0F00); tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0); check("mid_rst_wren", rd_wren, 0);
        check("mid_rst_ready", wb_ready, 3'b001);
        tick();

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r = wb_ready;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!wb_valid[i] || r[i]) begin
                    wb_valid[i] = 1'($urandom_range(0, 1));
                    set_wb(i, 5'($urandom_range(0, 7)), $urandom);
                end
            end
            set_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
        end
        wb_valid = '0;
        set_issue(0, 0, 0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        check("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
